// File: rtl/lfsr_offset_search.sv
// Finds how many Fibonacci LFSR steps from SEED reproduce a captured 17-bit sample.
// Offset 0 is returned for "not found" and for an all-zero polynomial or target.
module lfsr_offset_search #(
    parameter logic [16:0] SEED      = 17'h00001,
    parameter int          MAX_STEPS = 131071
) (
    input  logic        clk_72MHz,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [16:0] polynomial,
    input  logic [16:0] data,
    output logic [16:0] offset,
    output logic        ready
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam logic [16:0] STEP_LIMIT = 17'(MAX_STEPS);

    state_t      r_state;
    logic [16:0] r_poly;
    logic [16:0] r_data;
    logic [16:0] r_lfsr;
    logic [16:0] r_count;
    logic [16:0] r_offset;

    state_t      w_state_next;
    logic [16:0] w_poly_next;
    logic [16:0] w_data_next;
    logic [16:0] w_lfsr_next;
    logic [16:0] w_count_next;
    logic [16:0] w_offset_next;
    logic [16:0] w_lfsr_step;
    logic [16:0] w_count_inc;

    assign w_lfsr_step = {r_lfsr[15:0], ^(r_lfsr & r_poly)};
    assign w_count_inc = r_count + 17'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_state_next  = r_state;
        w_poly_next   = r_poly;
        w_data_next   = r_data;
        w_lfsr_next   = r_lfsr;
        w_count_next  = r_count;
        w_offset_next = r_offset;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_poly_next  = polynomial;
                    w_data_next  = data;
                    w_lfsr_next  = SEED;
                    w_count_next = '0;
                    w_state_next = SEARCH;
                end
            end
            SEARCH: begin
                // Abort outranks everything; the captured operands never change, so the
                // zero check gives the same answer every cycle and only matters on the first.
                if (!enable) begin
                    w_state_next = IDLE;
                end else if (r_poly == '0 || r_data == '0) begin
                    w_offset_next = '0;
                    w_state_next  = DONE;
                end else begin
                    w_lfsr_next  = w_lfsr_step;
                    w_count_next = w_count_inc;
                    if (w_lfsr_step == r_data) begin
                        w_offset_next = w_count_inc;
                        w_state_next  = DONE;
                    end else if (w_count_inc == STEP_LIMIT) begin
                        w_offset_next = '0;
                        w_state_next  = DONE;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_72MHz) begin
        // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
        if (!reset_n) begin
            r_state  <= IDLE;
            r_poly   <= '0;
            r_data   <= '0;
            r_lfsr   <= SEED;
            r_count  <= '0;
            r_offset <= '0;
        end else begin
            r_state  <= w_state_next;
            r_poly   <= w_poly_next;
            r_data   <= w_data_next;
            r_lfsr   <= w_lfsr_next;
            r_count  <= w_count_next;
            r_offset <= w_offset_next;
        end
    end

    assign offset = r_offset;
    assign ready  = (r_state != SEARCH);

endmodule

// File: tb/tb_lfsr_offset_search.sv
// Bench for lfsr_offset_search: scenario tasks compare DUT results with a step-by-step
// software LFSR model; the search limit is shortened so exhaustive cases finish quickly.
module tb_lfsr_offset_search;

    localparam logic [16:0] TB_SEED  = 17'h00001;
    localparam int          TB_MAX   = 4000;
    localparam logic [16:0] MAX_POLY = 17'h12000;

    logic        clk_72MHz = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic [16:0] polynomial = '0;
    logic [16:0] data       = '0;
    logic [16:0] offset;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    lfsr_offset_search #(
        .SEED      (TB_SEED),
        .MAX_STEPS (TB_MAX)
    ) dut (
        .clk_72MHz  (clk_72MHz),
        .reset_n    (reset_n),
        .enable     (enable),
        .polynomial (polynomial),
        .data       (data),
        .offset     (offset),
        .ready      (ready)
    );

    always #5 clk_72MHz = ~clk_72MHz;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Shift left by one, append the parity of the tapped bits.
    function automatic logic [16:0] model_next(input logic [16:0] s, input logic [16:0] p);
        int shifted;
        int fb;
        shifted = (int'(s) * 2) % 131072;
        fb      = $countones(s & p) % 2;
        return 17'(shifted + fb);
    endfunction

    function automatic logic [16:0] model_state_at(input logic [16:0] p, input int k);
        logic [16:0] s;
        s = TB_SEED;
        for (int i = 0; i < k; i++) s = model_next(s, p);
        return s;
    endfunction

    task automatic model_search(input logic [16:0] p, input logic [16:0] d,
                                output logic [16:0] exp_off, output int exp_low);
        logic [16:0] s;
        exp_off = '0;
        if (p == '0 || d == '0) begin
            exp_low = 1;
            return;
        end
        exp_low = TB_MAX;
        s = TB_SEED;
        for (int i = 1; i <= TB_MAX; i++) begin
            s = model_next(s, p);
            if (s == d) begin
                exp_off = 17'(i);
                exp_low = i;
                break;
            end
        end
    endtask

    // Starts a search from IDLE and measures how many cycles ready stays low.
    task automatic run_search(input logic [16:0] p, input logic [16:0] d,
                              output logic [16:0] got_off, output int got_low);
        @(negedge clk_72MHz);
        polynomial = p;
        data       = d;
        enable     = 1'b1;
        @(posedge clk_72MHz); #1;
        got_low = 0;
        while (ready !== 1'b1 && got_low < TB_MAX + 10) begin
            @(posedge clk_72MHz); #1;
            got_low++;
        end
        got_off = offset;
    endtask

    task automatic end_search();
        @(negedge clk_72MHz);
        enable = 1'b0;
        @(posedge clk_72MHz); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_72MHz);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b want=1", ready);
        end
        checks++;
        if (offset !== 17'd0) begin
            failures++;
            $display("FAIL reset_offset got=%0d want=0", offset);
        end
        @(negedge clk_72MHz);
        reset_n = 1'b1;
        @(posedge clk_72MHz); #1;
    endtask

    task automatic test_basic_match();
        logic [16:0] got_off;
        int          got_low;
        run_search(17'h00001, 17'h00007, got_off, got_low);
        checks++;
        if (got_low != 2) begin
            failures++;
            $display("FAIL basic_low got=%0d want=2", got_low);
        end
        checks++;
        if (got_off !== 17'd2) begin
            failures++;
            $display("FAIL basic_offset got=%0d want=2", got_off);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_72MHz);
            polynomial = 17'($urandom);
            data       = 17'($urandom);
            @(posedge clk_72MHz); #1;
            checks++;
            if (ready !== 1'b1 || offset !== 17'd2) begin
                failures++;
                $display("FAIL basic_hold got=%0b/%0d want=1/2", ready, offset);
            end
        end
        end_search();
    endtask

    task automatic test_unreachable();
        logic [16:0] got_off;
        int          got_low;
        run_search(17'h00001, 17'h00002, got_off, got_low);
        checks++;
        if (got_low != TB_MAX) begin
            failures++;
            $display("FAIL unreachable_low got=%0d want=%0d", got_low, TB_MAX);
        end
        checks++;
        if (got_off !== 17'd0) begin
            failures++;
            $display("FAIL unreachable_offset got=%0d want=0", got_off);
        end
        end_search();
    endtask

    task automatic test_invalid();
        logic [16:0] polys [4] = '{17'h00001, 17'h00000, 17'h00001, 17'h12000};
        logic [16:0] datas [4] = '{17'h00007, 17'h00155, 17'h00007, 17'h00000};
        logic [16:0] got_off;
        logic [16:0] exp_off;
        int          got_low;
        int          exp_low;
        for (int i = 0; i < 4; i++) begin
            model_search(polys[i], datas[i], exp_off, exp_low);
            run_search(polys[i], datas[i], got_off, got_low);
            checks++;
            if (got_low != exp_low) begin
                failures++;
                $display("FAIL invalid_low[%0d] got=%0d want=%0d", i, got_low, exp_low);
            end
            checks++;
            if (got_off !== exp_off) begin
                failures++;
                $display("FAIL invalid_offset[%0d] got=%0d want=%0d", i, got_off, exp_off);
            end
            end_search();
        end
    endtask

    task automatic test_maximal();
        int          steps [5] = '{1, 1000, 3000, TB_MAX, TB_MAX + 1};
        logic [16:0] target;
        logic [16:0] got_off;
        logic [16:0] exp_off;
        int          got_low;
        int          exp_low;
        for (int i = 0; i < 5; i++) begin
            target = model_state_at(MAX_POLY, steps[i]);
            model_search(MAX_POLY, target, exp_off, exp_low);
            run_search(MAX_POLY, target, got_off, got_low);
            checks++;
            if (got_off !== exp_off) begin
                failures++;
                $display("FAIL maximal_offset[%0d] got=%0d want=%0d", steps[i], got_off, exp_off);
            end
            checks++;
            if (got_low != exp_low) begin
                failures++;
                $display("FAIL maximal_low[%0d] got=%0d want=%0d", steps[i], got_low, exp_low);
            end
            end_search();
        end
    endtask

    task automatic test_random();
        logic [16:0] p;
        logic [16:0] d;
        logic [16:0] got_off;
        logic [16:0] exp_off;
        int          got_low;
        int          exp_low;
        for (int i = 0; i < 6; i++) begin
            p = 17'($urandom);
            if (i == 5) d = 17'($urandom);
            else        d = model_state_at(p, int'($urandom_range(1, TB_MAX)));
            model_search(p, d, exp_off, exp_low);
            run_search(p, d, got_off, got_low);
            checks++;
            if (got_off !== exp_off) begin
                failures++;
                $display("FAIL random_offset p=%h d=%h got=%0d want=%0d", p, d, got_off, exp_off);
            end
            checks++;
            if (got_low != exp_low) begin
                failures++;
                $display("FAIL random_low p=%h d=%h got=%0d want=%0d", p, d, got_low, exp_low);
            end
            end_search();
        end
    endtask

    task automatic test_abort_restart();
        logic [16:0] got_off;
        int          got_low;
        run_search(17'h00001, 17'h0001f, got_off, got_low);
        checks++;
        if (got_off !== 17'd4) begin
            failures++;
            $display("FAIL abort_setup_offset got=%0d want=4", got_off);
        end
        end_search();
        @(negedge clk_72MHz);
        polynomial = 17'h00001;
        data       = 17'h00002;
        enable     = 1'b1;
        repeat (10) @(posedge clk_72MHz);
        @(negedge clk_72MHz);
        enable = 1'b0;
        @(posedge clk_72MHz); #1;
        checks++;
        if (ready !== 1'b1 || offset !== 17'd4) begin
            failures++;
            $display("FAIL abort_state got=%0b/%0d want=1/4", ready, offset);
        end
        @(posedge clk_72MHz); #1;
        run_search(17'h00001, 17'h00007, got_off, got_low);
        checks++;
        if (got_off !== 17'd2 || got_low != 2) begin
            failures++;
            $display("FAIL restart got=%0d/%0d want=2/2", got_off, got_low);
        end
        end_search();
    endtask

    task automatic test_reset_mid_search();
        int got_low;
        @(negedge clk_72MHz);
        polynomial = 17'h00001;
        data       = 17'h00002;
        enable     = 1'b1;
        repeat (6) @(posedge clk_72MHz);
        @(negedge clk_72MHz);
        reset_n = 1'b0;
        data    = 17'h00007;
        @(posedge clk_72MHz); #1;
        checks++;
        if (ready !== 1'b1 || offset !== 17'd0) begin
            failures++;
            $display("FAIL midreset_state got=%0b/%0d want=1/0", ready, offset);
        end
        @(negedge clk_72MHz);
        reset_n = 1'b1;
        @(posedge clk_72MHz); #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_restart_ready got=%0b want=0", ready);
        end
        got_low = 0;
        while (ready !== 1'b1 && got_low < TB_MAX + 10) begin
            @(posedge clk_72MHz); #1;
            got_low++;
        end
        checks++;
        if (offset !== 17'd2 || got_low != 2) begin
            failures++;
            $display("FAIL midreset_result got=%0d/%0d want=2/2", offset, got_low);
        end
        end_search();
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_unreachable();
        test_invalid();
        test_maximal();
        test_random();
        test_abort_restart();
        test_reset_mid_search();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
